vga_timing_gen: RTL and testbench

- Parametrised VGA timing generator with a built-in pixel clock enable; successor to the fixed 640x480 sync block.
- Runs entirely on the 50 MHz system clock with a clock enable instead of a divided clock.
- Supplies pixel coordinates to game/render logic, aligns sync and blanking to a configurable render-pipeline latency, and blanks RGB outside the active area.
- Emits a frame tick and a divided game tick for game-state updates during vertical blanking.

---
 rtl/vga_timing_gen_if.sv | 35 +++
 rtl/vga_timing_gen.sv | 179 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: render handshake (coordinates out,
// colour in), frame/game ticks and the DAC/connector pins.
interface vga_timing_gen_if #(
  parameter int CW = 11
);
  logic [7:0]    in_r;
  logic [7:0]    in_g;
  logic [7:0]    in_b;
  logic [CW-1:0] px;
  logic [CW-1:0] py;
  logic          pix_ce;
  logic          de;
  logic          frame_tick;
  logic          game_tick;
  logic [7:0]    VGA_R;
  logic [7:0]    VGA_G;
  logic [7:0]    VGA_B;
  logic          VGA_HS;
  logic          VGA_VS;
  logic          VGA_BLANK_N;
  logic          VGA_SYNC_N;
  logic          VGA_CLK;

  modport master (
    input  in_r, in_g, in_b,
    output px, py, pix_ce, de, frame_tick, game_tick,
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK
  );

  modport slave (
    output in_r, in_g, in_b,
    input  px, py, pix_ce, de, frame_tick, game_tick,
    input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator running on CLOCK_50 with a pixel clock enable;
// sync/blank are delayed to match the render pipeline before the output register.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   CLK_DIV  = 2,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PIPE_LAT = 1,
  parameter int   GAME_DIV = 1,
  parameter int   CW       = 11
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  vga_timing_gen_if.master   vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = 4;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_TICK   = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0]    GD_LAST  = 8'(GAME_DIV - 1);

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  logic [DW-1:0] div_cnt_reg;
  logic          pix_ce_reg;
  logic          vga_clk_reg;
  logic [CW-1:0] h_cnt_reg;
  logic [CW-1:0] v_cnt_reg;
  logic [7:0]    frame_cnt_reg;
  logic          frame_tick_reg;
  logic          game_tick_reg;
  logic [7:0]    r_reg;
  logic [7:0]    g_reg;
  logic [7:0]    b_reg;
  logic          blank_n_reg;
  logic          hs_reg;
  logic          vs_reg;

  logic  h_wrap;
  logic  v_wrap;
  logic  frame_event;
  sync_t sync_raw;
  sync_t sync_dly;

  // Pixel enable and the outgoing pixel clock share one phase counter
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_cnt_reg <= '0;
      pix_ce_reg  <= 1'b0;
      vga_clk_reg <= 1'b0;
    end else begin
      div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DW'(1);
      pix_ce_reg  <= (div_cnt_reg == DIV_LAST);
      vga_clk_reg <= (div_cnt_reg >= DIV_HALF);
    end
  end

  assign h_wrap = (h_cnt_reg == H_LAST);
  assign v_wrap = (v_cnt_reg == V_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (pix_ce_reg) begin
      h_cnt_reg <= h_wrap ? '0 : h_cnt_reg + CW'(1);
      if (h_wrap) begin
        v_cnt_reg <= v_wrap ? '0 : v_cnt_reg + CW'(1);
      end
    end
  end

  // Last pixel of the last active line: the counters are about to enter vertical blanking
  assign frame_event = pix_ce_reg && h_wrap && (v_cnt_reg == V_TICK);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      frame_cnt_reg  <= '0;
      frame_tick_reg <= 1'b0;
      game_tick_reg  <= 1'b0;
    end else begin
      frame_tick_reg <= frame_event;
      game_tick_reg  <= frame_event && (frame_cnt_reg == GD_LAST);
      if (frame_event) begin
        frame_cnt_reg <= (frame_cnt_reg == GD_LAST) ? '0 : frame_cnt_reg + 8'd1;
      end
    end
  end

  assign sync_raw.de = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
  assign sync_raw.hs = (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
  assign sync_raw.vs = (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);

  // Delay line matching the render latency; stage 0 holds the newest pixel
  generate
    if (PIPE_LAT == 0) begin : g_nolat
      assign sync_dly = sync_raw;
    end else begin : g_lat
      sync_t stage_reg [PIPE_LAT];
      for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          always_ff @(posedge CLOCK_50) begin
            if (reset) begin
              stage_reg[gi] <= '0;
            end else if (pix_ce_reg) begin
              stage_reg[gi] <= sync_raw;
            end
          end
        end else begin : g_next
          always_ff @(posedge CLOCK_50) begin
            if (reset) begin
              stage_reg[gi] <= '0;
            end else if (pix_ce_reg) begin
              stage_reg[gi] <= stage_reg[gi-1];
            end
          end
        end
      end
      assign sync_dly = stage_reg[PIPE_LAT-1];
    end
  endgenerate

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_reg       <= '0;
      g_reg       <= '0;
      b_reg       <= '0;
      blank_n_reg <= 1'b0;
      hs_reg      <= ~HS_POL;
      vs_reg      <= ~VS_POL;
    end else if (pix_ce_reg) begin
      r_reg       <= sync_dly.de ? vga.in_r : 8'h00;
      g_reg       <= sync_dly.de ? vga.in_g : 8'h00;
      b_reg       <= sync_dly.de ? vga.in_b : 8'h00;
      blank_n_reg <= sync_dly.de;
      hs_reg      <= sync_dly.hs ? HS_POL : ~HS_POL;
      vs_reg      <= sync_dly.vs ? VS_POL : ~VS_POL;
    end
  end

  assign vga.px          = h_cnt_reg;
  assign vga.py          = v_cnt_reg;
  assign vga.pix_ce      = pix_ce_reg;
  assign vga.de          = sync_raw.de;
  assign vga.frame_tick  = frame_tick_reg;
  assign vga.game_tick   = game_tick_reg;
  assign vga.VGA_R       = r_reg;
  assign vga.VGA_G       = g_reg;
  assign vga.VGA_B       = b_reg;
  assign vga.VGA_HS      = hs_reg;
  assign vga.VGA_VS      = vs_reg;
  assign vga.VGA_BLANK_N = blank_n_reg;
  assign vga.VGA_SYNC_N  = 1'b0;
  assign vga.VGA_CLK     = vga_clk_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: two small-timing instances (CLK_DIV=4/PIPE_LAT=0/GAME_DIV=3 and
// CLK_DIV=2/PIPE_LAT=3/GAME_DIV=1) checked pixel by pixel after a mid-frame reset.
module tb_vga_timing_gen;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;
  localparam int RUN_CYCLES = 4 * FT * 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(11)) bus_a ();
  vga_timing_gen_if #(.CW(11)) bus_b ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(4), .HS_POL(1'b0), .VS_POL(1'b0),
    .PIPE_LAT(0), .GAME_DIV(3), .CW(11)
  ) dut_a (
    .CLOCK_50(clk),
    .reset(reset),
    .vga(bus_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(2), .HS_POL(1'b0), .VS_POL(1'b0),
    .PIPE_LAT(3), .GAME_DIV(1), .CW(11)
  ) dut_b (
    .CLOCK_50(clk),
    .reset(reset),
    .vga(bus_b)
  );

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected state of pixel index m counted from the reset release; m<0 is idle
  function automatic int pix_h(input int m);
    return (m % FT) % HT;
  endfunction
  function automatic int pix_v(input int m);
    return (m % FT) / HT;
  endfunction
  function automatic int exp_de(input int m);
    if (m < 0) return 0;
    return (pix_h(m) < 8 && pix_v(m) < 4) ? 1 : 0;
  endfunction
  function automatic int exp_hs(input int m);
    if (m < 0) return 1;
    return (pix_h(m) >= 10 && pix_h(m) < 13) ? 0 : 1;
  endfunction
  function automatic int exp_vs(input int m);
    if (m < 0) return 1;
    return (pix_v(m) == 5) ? 0 : 1;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_a_px"}, int'(bus_a.px), 0);
    check({tag, "_a_py"}, int'(bus_a.py), 0);
    check({tag, "_a_hs"}, int'(bus_a.VGA_HS), 1);
    check({tag, "_a_vs"}, int'(bus_a.VGA_VS), 1);
    check({tag, "_a_blank_n"}, int'(bus_a.VGA_BLANK_N), 0);
    check({tag, "_a_r"}, int'(bus_a.VGA_R), 0);
    check({tag, "_a_g"}, int'(bus_a.VGA_G), 0);
    check({tag, "_a_vga_clk"}, int'(bus_a.VGA_CLK), 0);
    check({tag, "_a_pix_ce"}, int'(bus_a.pix_ce), 0);
    check({tag, "_a_frame_tick"}, int'(bus_a.frame_tick), 0);
    check({tag, "_a_game_tick"}, int'(bus_a.game_tick), 0);
    check({tag, "_b_px"}, int'(bus_b.px), 0);
    check({tag, "_b_py"}, int'(bus_b.py), 0);
    check({tag, "_b_hs"}, int'(bus_b.VGA_HS), 1);
    check({tag, "_b_blank_n"}, int'(bus_b.VGA_BLANK_N), 0);
    check({tag, "_b_r"}, int'(bus_b.VGA_R), 0);
  endtask

  initial begin
    int found;
    int n;
    int m;
    int ft_a, gt_a, ft_b, gt_b;
    int blank_cnt, hs_low_cnt, vs_low_cnt;
    int h1, h2, h3;

    bus_a.in_r = 8'h5A;
    bus_a.in_g = 8'hFF;
    bus_a.in_b = 8'h00;
    bus_b.in_r = 8'h00;
    bus_b.in_g = 8'hFF;
    bus_b.in_b = 8'h00;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    reset = 1'b0;
    $display("phase power-on reset done");

    found = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (bus_a.px == 11'd5 && bus_a.py == 11'd2) begin
        found = 1;
        break;
      end
    end
    check("reach_h5_v2", found, 1);

    reset = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    @(negedge clk);
    @(negedge clk);
    check("midrst_a_frame_tick_hold", int'(bus_a.frame_tick), 0);
    check("midrst_a_px_hold", int'(bus_a.px), 0);
    reset = 1'b0;
    $display("phase mid-frame reset done");

    ft_a = 0; gt_a = 0; ft_b = 0; gt_b = 0;
    blank_cnt = 0; hs_low_cnt = 0; vs_low_cnt = 0;
    h1 = 0; h2 = 0; h3 = 0;
    bus_b.in_r = 8'h00;

    for (int c = 1; c <= RUN_CYCLES; c++) begin
      @(negedge clk);

      if (c <= 16) begin
        check($sformatf("a_pix_ce c=%0d", c), int'(bus_a.pix_ce), (c % 4 == 0) ? 1 : 0);
        check($sformatf("a_vga_clk c=%0d", c), int'(bus_a.VGA_CLK),
              (c % 4 == 0 || c % 4 == 3) ? 1 : 0);
        check($sformatf("b_pix_ce c=%0d", c), int'(bus_b.pix_ce), (c % 2 == 0) ? 1 : 0);
        check($sformatf("b_vga_clk c=%0d", c), int'(bus_b.VGA_CLK), (c % 2 == 0) ? 1 : 0);
      end

      if (bus_a.pix_ce) begin
        n = c / 4 - 1;
        m = n - 1;
        check($sformatf("a_px n=%0d", n), int'(bus_a.px), pix_h(n));
        check($sformatf("a_py n=%0d", n), int'(bus_a.py), pix_v(n));
        check($sformatf("a_blank_n n=%0d", n), int'(bus_a.VGA_BLANK_N), exp_de(m));
        check($sformatf("a_hs n=%0d", n), int'(bus_a.VGA_HS), exp_hs(m));
        check($sformatf("a_vs n=%0d", n), int'(bus_a.VGA_VS), exp_vs(m));
        check($sformatf("a_r n=%0d", n), int'(bus_a.VGA_R), exp_de(m) != 0 ? 8'h5A : 0);
        check($sformatf("a_g n=%0d", n), int'(bus_a.VGA_G), exp_de(m) != 0 ? 8'hFF : 0);
        if (n >= 1 && n <= FT) begin
          if (bus_a.VGA_BLANK_N) blank_cnt++;
          if (!bus_a.VGA_HS) hs_low_cnt++;
          if (!bus_a.VGA_VS) vs_low_cnt++;
        end
      end

      if (bus_a.frame_tick) begin
        ft_a++;
        check($sformatf("a_tick_px f=%0d", ft_a), int'(bus_a.px), 0);
        check($sformatf("a_tick_py f=%0d", ft_a), int'(bus_a.py), 4);
        check($sformatf("a_tick_cycle f=%0d", ft_a), c, 4 * ((ft_a - 1) * FT + 56) + 1);
        check($sformatf("a_game_tick f=%0d", ft_a), int'(bus_a.game_tick),
              (ft_a % 3 == 0) ? 1 : 0);
        $display("frame_tick a frame=%0d cycle=%0d game_tick=%0d", ft_a, c, bus_a.game_tick);
      end
      if (bus_a.game_tick) begin
        gt_a++;
        check("a_game_needs_frame", int'(bus_a.frame_tick), 1);
      end

      if (bus_b.pix_ce) begin
        n = c / 2 - 1;
        m = n - 4;
        check($sformatf("b_px n=%0d", n), int'(bus_b.px), pix_h(n));
        check($sformatf("b_blank_n n=%0d", n), int'(bus_b.VGA_BLANK_N), exp_de(m));
        check($sformatf("b_hs n=%0d", n), int'(bus_b.VGA_HS), exp_hs(m));
        check($sformatf("b_vs n=%0d", n), int'(bus_b.VGA_VS), exp_vs(m));
        check($sformatf("b_r n=%0d", n), int'(bus_b.VGA_R), exp_de(m) != 0 ? pix_h(m) : 0);
        check($sformatf("b_g n=%0d", n), int'(bus_b.VGA_G), exp_de(m) != 0 ? 8'hFF : 0);
        // Render model: colour for a pixel arrives three pixel periods after its px
        bus_b.in_r = 8'(h3);
        h3 = h2;
        h2 = h1;
        h1 = int'(bus_b.px);
      end

      if (bus_b.frame_tick || bus_b.game_tick) begin
        check("b_game_eq_frame", int'(bus_b.game_tick), int'(bus_b.frame_tick));
        if (bus_b.frame_tick) ft_b++;
        if (bus_b.game_tick) gt_b++;
      end
    end

    check("a_frame_ticks", ft_a, 7);
    check("a_game_ticks", gt_a, 2);
    check("b_frame_ticks", ft_b, 14);
    check("b_game_ticks", gt_b, 14);
    check("a_blank_n_high_per_frame", blank_cnt, 32);
    check("a_hs_low_per_frame", hs_low_cnt, 21);
    check("a_vs_low_per_frame", vs_low_cnt, 14);
    check("a_sync_n", int'(bus_a.VGA_SYNC_N), 0);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
